// File: rtl/fp_pkg.sv
// Shared types and constants for the FP adder normalization stage.
package fp_pkg;

    localparam int unsigned FP_MANT_W = 24;
    localparam int unsigned FP_EXP_W  = 8;
    localparam int unsigned EXP_BIAS  = 127;
    localparam logic [FP_EXP_W-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        NORM  = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } norm_state_e;

    typedef struct packed {
        logic                  sign;
        logic [FP_EXP_W-1:0]   exp;
        logic [FP_MANT_W-2:0]  frac;
    } fp32_t;

endpackage

// File: rtl/fp_normalizer.sv
// Post-ALU normalizer: iterative left shifter, packs {sign, exp, frac}.
// Optional ties-to-even rounding stage when FPN_ROUND_EN is defined.
module fp_normalizer
    import fp_pkg::*;
#(
    parameter int unsigned MANT_W = FP_MANT_W,
    parameter int unsigned EXP_W  = FP_EXP_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      carry_out_i,
    input  logic [MANT_W-1:0]         aligned_result_i,
    input  logic [EXP_W-1:0]          aligned_exp_i,
    input  logic                      result_sign_i,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+MANT_W-1:0]   result_o,
    output logic                      overflow_o,
    output logic                      zero_o
);

    localparam int unsigned RES_W = 1 + EXP_W + MANT_W - 1;
    localparam int unsigned XW    = EXP_W + 1;
    localparam logic [XW-1:0] EXP_ONES = {1'b0, {EXP_W{1'b1}}};
    localparam logic [RES_W-1:0] INF_MAG = {1'b0, {EXP_W{1'b1}}, {(MANT_W-1){1'b0}}};

`ifdef FPN_ROUND_EN
    localparam int unsigned RW = MANT_W + 1;
    localparam norm_state_e AFTER_NORM = ROUND;
`else
    localparam norm_state_e AFTER_NORM = DONE;
`endif

    norm_state_e              state_q, state_d;
    logic [MANT_W-1:0]        mant_q, mant_d;
    logic [XW-1:0]            exp_q, exp_d;
    logic                     sign_q, sign_d;
    logic [RES_W-1:0]         result_d;
    logic                     overflow_d, zero_d;
    logic [XW-1:0]            exp_in;

`ifdef FPN_ROUND_EN
    logic                     guard_q, guard_d;
    logic                     skip_q, skip_d;
    logic [RW-1:0]            rsum;
`endif

    // Exponent 0 (denormal operand) behaves as exponent 1.
    assign exp_in = (aligned_exp_i == '0) ? XW'(1) : {1'b0, aligned_exp_i};

    function automatic logic [RES_W-1:0] pack_word(input logic s,
                                                   input logic [XW-1:0] e,
                                                   input logic [MANT_W-1:0] m);
        logic [EXP_W-1:0] ef;
        ef = m[MANT_W-1] ? e[EXP_W-1:0] : '0;
        return {s, ef, m[MANT_W-2:0]};
    endfunction

    always_comb begin
        state_d    = state_q;
        mant_d     = mant_q;
        exp_d      = exp_q;
        sign_d     = sign_q;
        result_d   = result_o;
        overflow_d = overflow_o;
        zero_d     = zero_o;
`ifdef FPN_ROUND_EN
        guard_d    = guard_q;
        skip_d     = skip_q;
        rsum       = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d    = NORM;
                    sign_d     = result_sign_i;
                    overflow_d = 1'b0;
                    zero_d     = 1'b0;
                    if (carry_out_i) begin
                        mant_d = {1'b1, aligned_result_i[MANT_W-1:1]};
                        exp_d  = exp_in + XW'(1);
                    end else begin
                        mant_d = aligned_result_i;
                        exp_d  = exp_in;
                    end
`ifdef FPN_ROUND_EN
                    guard_d = carry_out_i & aligned_result_i[0];
                    skip_d  = 1'b0;
`endif
                end
            end
            NORM: begin
                state_d = AFTER_NORM;
                if (mant_q == '0) begin
                    result_d = '0;
                    zero_d   = 1'b1;
`ifdef FPN_ROUND_EN
                    skip_d   = 1'b1;
`endif
                end else if (exp_q >= EXP_ONES) begin
                    result_d   = INF_MAG | {sign_q, {(RES_W-1){1'b0}}};
                    overflow_d = 1'b1;
`ifdef FPN_ROUND_EN
                    skip_d     = 1'b1;
`endif
                end else if (!mant_q[MANT_W-1] && exp_q > XW'(1)) begin
                    state_d = NORM;
                    mant_d  = {mant_q[MANT_W-2:0], 1'b0};
                    exp_d   = exp_q - XW'(1);
                end else begin
                    // Normal, or denormal floor reached (exp 1 with MSB clear).
                    result_d = pack_word(sign_q, exp_q, mant_q);
                end
            end
            ROUND: begin
                state_d = DONE;
`ifdef FPN_ROUND_EN
                if (!skip_q && guard_q && mant_q[0]) begin
                    rsum = {1'b0, mant_q} + RW'(1);
                    if (rsum[MANT_W]) begin
                        mant_d = rsum[MANT_W:1];
                        exp_d  = exp_q + XW'(1);
                    end else begin
                        mant_d = rsum[MANT_W-1:0];
                    end
                    if (exp_d >= EXP_ONES) begin
                        result_d   = INF_MAG | {sign_q, {(RES_W-1){1'b0}}};
                        overflow_d = 1'b1;
                    end else begin
                        result_d = pack_word(sign_q, exp_d, mant_d);
                    end
                end
`endif
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            mant_q     <= '0;
            exp_q      <= '0;
            sign_q     <= 1'b0;
            result_o   <= '0;
            overflow_o <= 1'b0;
            zero_o     <= 1'b0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
`ifdef FPN_ROUND_EN
            guard_q    <= 1'b0;
            skip_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            mant_q     <= mant_d;
            exp_q      <= exp_d;
            sign_q     <= sign_d;
            result_o   <= result_d;
            overflow_o <= overflow_d;
            zero_o     <= zero_d;
            in_ready   <= (state_d == IDLE);
            out_valid  <= (state_d == DONE);
`ifdef FPN_ROUND_EN
            guard_q    <= guard_d;
            skip_q     <= skip_d;
`endif
        end
    end

endmodule

// File: tb/tb_fp_normalizer.sv
// Scoreboard bench for fp_normalizer: directed vectors plus modelled random ops.
module tb_fp_normalizer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        carry_out_i = 1'b0;
    logic [23:0] aligned_result_i = '0;
    logic [7:0]  aligned_exp_i = '0;
    logic        result_sign_i = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result_o;
    logic        overflow_o;
    logic        zero_o;

    typedef struct packed {
        logic [31:0] word;
        logic        ovf;
        logic        zero;
        logic [7:0]  lat;
    } sb_t;

`ifdef FPN_ROUND_EN
    localparam int RL = 1;
    localparam logic [31:0] ROUND_WORD = 32'h4000_0002;
`else
    localparam int RL = 0;
    localparam logic [31:0] ROUND_WORD = 32'h4000_0001;
`endif

    sb_t sb_q[$];
    int  n_checks = 0;
    int  n_fail = 0;

    fp_normalizer dut (
        .clk              (clk),
        .reset            (reset),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .carry_out_i      (carry_out_i),
        .aligned_result_i (aligned_result_i),
        .aligned_exp_i    (aligned_exp_i),
        .result_sign_i    (result_sign_i),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .result_o         (result_o),
        .overflow_o       (overflow_o),
        .zero_o           (zero_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got=0x%08h want=0x%08h", tag, got, want);
        end
    endtask

    // Reference built from the leading-one position rather than stepwise shifting.
    function automatic sb_t model(input logic c, input logic [23:0] r, input logic [7:0] e,
                                  input logic s);
        sb_t o;
        logic [24:0] v;
        logic [24:0] m;
        int ee;
        int p;
        int k;
        o  = '0;
        v  = {c, r};
        ee = (e == 8'd0) ? 1 : int'(e);
        k  = 0;
        p  = -1;
        m  = '0;
        for (int i = 0; i < 25; i++) if (v[i]) p = i;
        if (v == 25'd0) begin
            o.zero = 1'b1;
        end else begin
            if (p == 24) begin
                m = v >> 1;
                ee++;
            end else begin
                m = v;
            end
            if (ee >= 255) begin
                o.ovf = 1'b1;
            end else if (p < 24) begin
                k = 23 - p;
                if (k > ee - 1) k = ee - 1;
                m  = m << k;
                ee = ee - k;
            end
        end
        o.lat = 8'(k + 1 + RL);
`ifdef FPN_ROUND_EN
        if (!o.zero && !o.ovf && c && r[0] && m[0]) begin
            m = m + 25'd1;
            if (m[24]) begin
                m  = m >> 1;
                ee++;
                if (ee >= 255) o.ovf = 1'b1;
            end
        end
`endif
        if (o.zero)      o.word = 32'd0;
        else if (o.ovf)  o.word = {s, 8'hFF, 23'd0};
        else             o.word = {s, (m[23] ? 8'(ee) : 8'd0), m[22:0]};
        return o;
    endfunction

    function automatic sb_t mk(input logic [31:0] w, input logic ovf, input logic zero, input int lat);
        sb_t o;
        o.word = w;
        o.ovf  = ovf;
        o.zero = zero;
        o.lat  = 8'(lat + RL);
        return o;
    endfunction

    task automatic run_op(input logic c, input logic [23:0] r, input logic [7:0] e,
                          input logic s, input sb_t want, input int hold);
        sb_t exp_v;
        int n;
        logic [31:0] held;
        sb_q.push_back(want);
        carry_out_i      = c;
        aligned_result_i = r;
        aligned_exp_i    = e;
        result_sign_i    = s;
        out_ready        = (hold == 0);
        in_valid         = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_eq("busy_in_ready", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 200) begin
            @(posedge clk); #1; n++;
        end
        exp_v = sb_q.pop_front();
        if (!out_valid) begin
            check_eq("out_valid_timeout", 32'(out_valid), 32'd1);
            out_ready = 1'b1;
            return;
        end
        check_eq("latency", 32'(n), 32'(exp_v.lat));
        check_eq("result", result_o, exp_v.word);
        check_eq("overflow", 32'(overflow_o), 32'(exp_v.ovf));
        check_eq("zero", 32'(zero_o), 32'(exp_v.zero));
        held = result_o;
        for (int i = 0; i < hold; i++) begin
            in_valid         = 1'b1;
            aligned_result_i = ~r;
            @(posedge clk); #1;
            check_eq("hold_result", result_o, held);
            check_eq("hold_valid", 32'(out_valid), 32'd1);
            check_eq("hold_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("release_valid", 32'(out_valid), 32'd0);
        check_eq("release_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        seen;
        logic        rc;
        logic [23:0] rr;
        logic [7:0]  re;
        logic        rs;
        int          sel;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_result", result_o, 32'd0);
        check_eq("rst_overflow", 32'(overflow_o), 32'd0);
        check_eq("rst_zero", 32'(zero_o), 32'd0);

        run_op(1'b1, 24'h000000, 8'd127, 1'b0, mk(32'h4000_0000, 1'b0, 1'b0, 1), 0);
        run_op(1'b0, 24'h000001, 8'd127, 1'b1, mk(32'hB400_0000, 1'b0, 1'b0, 24), 0);
        run_op(1'b0, 24'h000000, 8'd100, 1'b1, mk(32'h0000_0000, 1'b0, 1'b1, 1), 0);
        run_op(1'b1, 24'h000000, 8'd254, 1'b0, mk(32'h7F80_0000, 1'b1, 1'b0, 1), 0);
        run_op(1'b0, 24'h000010, 8'd3,   1'b0, mk(32'h0000_0040, 1'b0, 1'b0, 3), 0);
        run_op(1'b1, 24'h000003, 8'd127, 1'b0, mk(ROUND_WORD,    1'b0, 1'b0, 1), 0);
        run_op(1'b0, 24'h000100, 8'd0,   1'b1, mk(32'h8000_0100, 1'b0, 1'b0, 1), 0);
        run_op(1'b1, 24'h000000, 8'd127, 1'b0, mk(32'h4000_0000, 1'b0, 1'b0, 1), 5);

        // Reset while shifting must drop the operation entirely.
        carry_out_i      = 1'b0;
        aligned_result_i = 24'h000001;
        aligned_exp_i    = 8'd127;
        result_sign_i    = 1'b0;
        in_valid         = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_eq("midrst_in_ready", 32'(in_ready), 32'd1);
        check_eq("midrst_out_valid", 32'(out_valid), 32'd0);
        check_eq("midrst_result", result_o, 32'd0);
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check_eq("midrst_no_valid", 32'(seen), 32'd0);

        for (int i = 0; i < 16; i++) begin
            rc  = ($urandom_range(0, 3) == 0);
            rr  = 24'($urandom) >> $urandom_range(0, 23);
            sel = $urandom_range(0, 5);
            case (sel)
                0:       re = 8'd0;
                1:       re = 8'd1;
                2:       re = 8'd254;
                3:       re = 8'd255;
                default: re = 8'($urandom_range(2, 253));
            endcase
            rs = 1'($urandom);
            run_op(rc, rr, re, rs, model(rc, rr, re, rs), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
